// File: rtl/genbuf_gr1_monitor_if.sv
// rtl/genbuf_gr1_monitor_if.sv - GenBuf GR1 monitor observation and status bundle
interface genbuf_gr1_monitor_if #(
   parameter int N_RCV = 2,
   parameter int TW    = $clog2(N_RCV),
   parameter int CW    = 8
);
   logic [N_RCV-1:0] b_to_r_req_p;
   logic             empty_p;
   logic             deq_p;
   logic             err_clr;
   logic [TW-1:0]    turn;
   logic             busy;
   logic             accept;
   logic [CW-1:0]    done_cnt;
   logic [7:0]       wait_cnt;
   logic             err_order;
   logic             err_multi;
   logic             err_starve;
   logic [1:0]       first_err;

   modport master (
      output b_to_r_req_p, empty_p, deq_p, err_clr,
      input  turn, busy, accept, done_cnt, wait_cnt,
             err_order, err_multi, err_starve, first_err
   );

   modport slave (
      input  b_to_r_req_p, empty_p, deq_p, err_clr,
      output turn, busy, accept, done_cnt, wait_cnt,
             err_order, err_multi, err_starve, first_err
   );
endinterface

// File: rtl/genbuf_gr1_monitor.sv
// rtl/genbuf_gr1_monitor.sv - round-robin request (G7) and bounded-wait dequeue (G12) checker
module genbuf_gr1_monitor #(
   parameter int N_RCV    = 2,
   parameter int TW       = $clog2(N_RCV),
   parameter int MAX_WAIT = 8,
   parameter int CW       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   genbuf_gr1_monitor_if.slave  mon
);
   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t        state_q, state_n;
   logic [TW-1:0] turn_q, turn_n, act_q, act_n;
   logic          accept_q, accept_n;
   logic [CW-1:0] done_q, done_n;
   logic [7:0]    wait_q, wait_n;
   logic          err_order_q, err_order_n;
   logic          err_multi_q, err_multi_n;
   logic          err_starve_q, err_starve_n;
   logic [1:0]    first_q, first_n, first_base;
   logic          set_order, set_multi, set_starve;
   logic [4:0]    pc;
   logic [TW-1:0] req_idx, turn_wrap;
   logic [CW-1:0] done_inc;

   always_comb begin
      pc      = '0;
      req_idx = '0;
      for (int i = 0; i < N_RCV; i++) begin
         if (mon.b_to_r_req_p[i]) begin
            pc      = pc + 5'd1;
            req_idx = TW'(i);
         end
      end
   end

   // Explicit compare keeps the wrap exact for non-power-of-2 receiver counts
   assign turn_wrap = (act_q == TW'(N_RCV - 1)) ? '0 : act_q + TW'(1);
   assign done_inc  = (done_q == '1) ? done_q : done_q + CW'(1);

   always_comb begin
      state_n   = state_q;
      turn_n    = turn_q;
      act_n     = act_q;
      accept_n  = 1'b0;
      done_n    = done_q;
      set_order = 1'b0;
      set_multi = 1'b0;
      if (pc > 5'd1) begin
         set_multi = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (pc == 5'd1) begin
                  state_n = ACTIVE;
                  act_n   = req_idx;
                  if (req_idx != turn_q) begin
                     set_order = 1'b1;
                     turn_n    = req_idx;
                  end
               end
            end
            ACTIVE: begin
               if (pc == 5'd0) begin
                  state_n  = IDLE;
                  turn_n   = turn_wrap;
                  accept_n = 1'b1;
                  done_n   = done_inc;
               end else if (req_idx != act_q) begin
                  set_order = 1'b1;
                  accept_n  = 1'b1;
                  done_n    = done_inc;
                  act_n     = req_idx;
                  turn_n    = req_idx;
               end
            end
         endcase
      end
   end

   always_comb begin
      wait_n     = wait_q;
      set_starve = 1'b0;
      if (mon.empty_p || mon.deq_p) begin
         wait_n = '0;
      end else if (wait_q != 8'hFF) begin
         wait_n     = wait_q + 8'd1;
         set_starve = ((wait_q + 8'd1) == 8'(MAX_WAIT));
      end
   end

   // A violation seen alongside err_clr still lands after the clear
   always_comb begin
      err_order_n  = (mon.err_clr ? 1'b0 : err_order_q)  | set_order;
      err_multi_n  = (mon.err_clr ? 1'b0 : err_multi_q)  | set_multi;
      err_starve_n = (mon.err_clr ? 1'b0 : err_starve_q) | set_starve;
      first_base   = mon.err_clr ? 2'd0 : first_q;
      first_n      = first_base;
      if (first_base == 2'd0) begin
         if (set_order)       first_n = 2'd1;
         else if (set_multi)  first_n = 2'd2;
         else if (set_starve) first_n = 2'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         turn_q       <= '0;
         act_q        <= '0;
         accept_q     <= 1'b0;
         done_q       <= '0;
         wait_q       <= '0;
         err_order_q  <= 1'b0;
         err_multi_q  <= 1'b0;
         err_starve_q <= 1'b0;
         first_q      <= 2'd0;
      end else begin
         state_q      <= state_n;
         turn_q       <= turn_n;
         act_q        <= act_n;
         accept_q     <= accept_n;
         done_q       <= done_n;
         wait_q       <= wait_n;
         err_order_q  <= err_order_n;
         err_multi_q  <= err_multi_n;
         err_starve_q <= err_starve_n;
         first_q      <= first_n;
      end
   end

   assign mon.turn       = turn_q;
   assign mon.busy       = (state_q == ACTIVE);
   assign mon.accept     = accept_q;
   assign mon.done_cnt   = done_q;
   assign mon.wait_cnt   = wait_q;
   assign mon.err_order  = err_order_q;
   assign mon.err_multi  = err_multi_q;
   assign mon.err_starve = err_starve_q;
   assign mon.first_err  = first_q;
endmodule

// File: doc/genbuf_gr1_monitor.md
Name: genbuf_gr1_monitor

Overview:
- Registered, parametrised successor to the GenBuf GR1 guarantee automata.
- Checks two guarantees online:
  - G7 generalised from two receivers to N_RCV receivers: one request at a time, served in strict round-robin order.
  - G12 strengthened from an unbounded "eventually dequeue" automaton to a bounded-wait check.
- Sits beside the GenBuf buffer as a bind-in checker. Reports sticky violations, a Büchi accept pulse and a small completion counter.

Parameters:
- N_RCV, 2, number of receivers (2..16).
- TW, $clog2(N_RCV), width of the turn/index fields.
- MAX_WAIT, 8, cycles non-empty without deq before G12 starvation is flagged (1..255).
- CW, 8, width of the completion counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- b_to_r_req_p  input  N_RCV  buffer-to-receiver request lines.
- empty_p  input  1  buffer empty.
- deq_p  input  1  dequeue strobe.
- err_clr  input  1  synchronous clear of sticky errors and first_err.
- turn  output  TW  receiver index currently entitled to the next request.
- busy  output  1  a request is in progress.
- accept  output  1  one-cycle Büchi accept pulse.
- done_cnt  output  CW  saturating count of completed requests.
- wait_cnt  output  8  cycles the buffer has been non-empty without deq.
- err_order  output  1  sticky: request to a receiver that is not the turn.
- err_multi  output  1  sticky: more than one request line high.
- err_starve  output  1  sticky: wait_cnt reached MAX_WAIT.
- first_err  output  2  code of the first error since reset/clear: 0 none, 1 order, 2 multi, 3 starve.

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - rst_n low at an edge: turn=0, busy=0, accept=0, done_cnt=0, wait_cnt=0, all err_*=0, first_err=0.
  - Reset wins over every other input, including mid-request.
- Outputs:
  - All outputs are registered.
  - Violations and accept appear the cycle after the offending or completing sample.
- G7 state: busy and act_idx (internal, TW bits). Let R = b_to_r_req_p and pc = popcount(R).
- IDLE (busy=0):
  - pc=0: stay in IDLE.
  - pc=1 at index i, i==turn: busy<=1, act_idx<=i.
  - pc=1, i!=turn: err_order<=1. Resynchronise: busy<=1, act_idx<=i, turn<=i.
- ACTIVE (busy=1):
  - R is one-hot at act_idx: hold.
  - pc=0 (completion): busy<=0, turn<=(act_idx+1) mod N_RCV, accept<=1, done_cnt<=done_cnt+1.
    - Turn wrap: N_RCV-1 -> 0; the mod is exact for non-power-of-2 N_RCV.
    - done_cnt saturates at 2^CW-1.
  - pc=1 at j!=act_idx (switch with no idle gap): err_order<=1. Treat as completion of act_idx followed by start of j:
    - accept<=1 and done_cnt increments.
    - act_idx<=j, turn<=j, busy stays 1.
- Any state, pc>1: err_multi<=1. busy, turn and act_idx are unchanged, and no accept.
- accept is 0 in every cycle not listed above.
- G12 bounded wait:
  - empty_p=1 or deq_p=1: wait_cnt<=0.
  - Otherwise wait_cnt<=wait_cnt+1, saturating at 255.
  - When the incremented value equals MAX_WAIT: err_starve<=1.
- Sticky errors:
  - err_* stay high until reset or err_clr.
  - first_err is captured only when it is 0 and at least one error is set this edge.
  - Priority on simultaneous errors: order > multi > starve.
- err_clr:
  - Clears err_* and first_err at the edge.
  - A violation detected in the same cycle as err_clr wins: the flag is set and first_err is captured.
  - err_clr does not touch turn, busy, done_cnt or wait_cnt.

Test Plan:
- N_RCV=3: reqs 0,1,2,0, each held 2 cycles with 1 idle cycle between -> turn sequence 0,1,2,0,1; four accept pulses; done_cnt=4; no errors.
- N_RCV=3, turn=0: req[2] high -> err_order=1, first_err=1, turn=2; after release, turn=0 (wrap).
- R=3'b011 for 1 cycle while idle -> err_multi=1, first_err=2, busy=0, turn unchanged, accept=0.
- MAX_WAIT=4: empty_p=0, deq_p=0 for 4 cycles -> wait_cnt=4, err_starve=1, first_err=3; a deq then gives wait_cnt=0 with err_starve still 1.
- Active on 0, req switches directly 0->1 -> err_order=1, accept pulse, done_cnt+1, busy stays 1, act_idx=1.
- rst_n low mid-request with errors set -> all outputs zero next cycle. err_clr asserted with a simultaneous multi violation -> err_multi=1, first_err=2.
